audio_i2s_tx: RTL and testbench
===============================

Name: audio_i2s_tx

Overview:
- Downstream consumer of the effect chain's final stage. Takes one signed 16-bit mono sample per i_valid pulse and serializes it to the codec DAC as an I2S master.
- Generates BCLK and LRCK from i_clk and drives DACDAT.
- Each sample is sent on both left and right channels.
- A one-entry holding buffer decouples the effect-chain sample strobe from the serial frame timing.

Parameters:
- BCLK_DIV, 4, i_clk cycles per BCLK half-period (>=2); BCLK period = 2*BCLK_DIV clocks.
- DATA_W, 16, sample width; frame = 2*DATA_W BCLK periods.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, synchronous, active-high
- i_valid  in  1  one-cycle sample strobe from the upstream effect stage
- i_data  in  DATA_W  signed sample, captured when i_valid=1
- i_mute  in  1  when high at frame start, transmit zero instead of the buffer contents
- o_bclk  out  1  I2S bit clock
- o_lrck  out  1  I2S word select; 0 = left, 1 = right
- o_dacdat  out  1  serial data, MSB first
- o_buf_full  out  1  holding buffer occupied
- o_underrun  out  1  one-cycle pulse: frame started with the buffer empty
- o_overflow  out  1  one-cycle pulse: buffer overwritten before it was consumed

Behaviour:
- Reset (i_rst=1 at a clock edge) gives these values on the next cycle:
  - o_bclk=0, o_lrck=1, o_dacdat=0.
  - o_buf_full=0, o_underrun=0, o_overflow=0.
  - Divider count=0, slot counter=2*DATA_W-1, last_sample=0, shift register=0.
- Reset mid-frame aborts the frame immediately; no partial-frame completion.
- Divider:
  - Counts 0..BCLK_DIV-1; o_bclk toggles on the clock where the count wraps.
  - First rise of o_bclk occurs BCLK_DIV clocks after reset release.
- All serial outputs change only in the clock where o_bclk goes 1->0 (the falling edge).
- Slot counter:
  - Increments modulo 2*DATA_W at each falling edge.
  - The first falling edge after reset yields slot 0.
- o_lrck = 0 for slots 0..DATA_W-1 and 1 for slots DATA_W..2*DATA_W-1.
- One-bit I2S delay on o_dacdat:
  - Slot 0 carries bit 0 of the previous frame's word.
  - Slots 1..DATA_W carry bits DATA_W-1..0 (left).
  - Slot DATA_W+1 through slot 2*DATA_W-1, then slot 0 of the next frame, carry bits DATA_W-1..0 (right).
- Frame load (at the slot-0 falling edge):
  - Frame word = 0 if i_mute; else the buffer if full; else last_sample.
  - When the buffer is full, clear o_buf_full and set last_sample = buffer; this happens even when muted.
  - If the buffer is empty, pulse o_underrun for one cycle, even when muted; last_sample is unchanged.
  - The right channel retransmits the same frame word.
- Buffer write (on any cycle with i_valid=1):
  - Store i_data and set o_buf_full.
  - If the buffer was already full and is not being consumed that same cycle, pulse o_overflow; the newest sample wins.
- Simultaneous i_valid and frame load:
  - The old buffer value is loaded into the frame.
  - The new i_data is stored and o_buf_full stays 1.
  - No overflow pulse.
- Throughput:
  - One sample per 4*DATA_W*BCLK_DIV clocks, which is 128 clocks at DATA_W=16, BCLK_DIV=2.
  - Upstream strobes faster than this overflow; strobes slower than this underrun.
- Latency: a sample accepted before a slot-0 edge has its MSB on o_dacdat from the slot-1 falling edge, i.e. 2*BCLK_DIV clocks after the load.
- No arithmetic on the data; bits pass through unmodified. Signed data is transmitted two's-complement.

Test Plan (BCLK_DIV=2, DATA_W=16):
- Reset release, no stimulus:
  - o_bclk first rises 2 clocks after release and has period 4 clocks.
  - o_lrck falls with the first o_bclk fall; o_lrck has period 128 clocks.
  - o_underrun pulses each frame; o_dacdat stays 0.
- i_valid with i_data=16'hA5C3 before the first slot 0:
  - Left slots 1..16 and right slots 17..31 plus next slot 0 both shift out 1010010111000011.
  - o_buf_full clears at the slot-0 load; no o_underrun on that frame.
- Samples 16'h8001 then 16'h7FFE written one frame apart, then no further writes:
  - Frames carry 8001 then 7FFE.
  - The third frame repeats 7FFE with an o_underrun pulse.
- Two i_valid pulses (16'h1111, 16'h2222) within one frame: o_overflow pulses on the second; the next frame transmits 2222.
- i_valid=1 with 16'h3C3C on exactly the slot-0 load clock while the buffer holds 16'h1234:
  - The frame transmits 1234 and the buffer holds 3C3C with o_buf_full=1.
  - No o_overflow pulse.
- Mute and reset:
  - i_mute=1 at slot 0 with the buffer holding 16'hFFFF: the frame is all zeros and the buffer is consumed.
  - Assert i_rst at slot 20: all outputs reach their reset values next cycle, and the timing restarts as in scenario 1.

Source files
------------

// File: rtl/audio_i2s_tx.sv
// I2S master transmitter: one mono sample per strobe, sent on both channels,
// buffered through a one-entry holding register ahead of the serial frame.
module audio_i2s_tx #(
  parameter int BCLK_DIV = 4,
  parameter int DATA_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_mute,
  output logic              o_bclk,
  output logic              o_lrck,
  output logic              o_dacdat,
  output logic              o_buf_full,
  output logic              o_underrun,
  output logic              o_overflow
);

  localparam int SLOTS = 2 * DATA_W;
  localparam int SW    = $clog2(SLOTS);
  localparam int CW    = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

  logic [CW-1:0]     r_div_cnt;
  logic              r_bclk;
  logic              r_lrck;
  logic              r_dacdat;
  logic [SW-1:0]     r_slot;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_last;
  logic [DATA_W-1:0] r_buf;
  logic              r_buf_full;
  logic              r_underrun;
  logic              r_overflow;

  logic              w_wrap;
  logic              w_fall;
  logic              w_load;
  logic [SW-1:0]     w_slot_nxt;
  logic [DATA_W-1:0] w_frame_word;

  assign w_wrap     = (r_div_cnt == CW'(BCLK_DIV - 1));
  assign w_fall     = w_wrap & r_bclk;
  assign w_slot_nxt = (r_slot == SW'(SLOTS - 1)) ? '0 : r_slot + 1'b1;
  assign w_load     = w_fall & (r_slot == SW'(SLOTS - 1));
  // Mute only replaces what goes on the wire; the buffer is still consumed.
  assign w_frame_word = i_mute     ? '0 :
                        r_buf_full ? r_buf : r_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_cnt  <= '0;
      r_bclk     <= 1'b0;
      r_lrck     <= 1'b1;
      r_dacdat   <= 1'b0;
      r_slot     <= SW'(SLOTS - 1);
      r_shift    <= '0;
      r_last     <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
      r_div_cnt  <= w_wrap ? '0 : r_div_cnt + 1'b1;
      if (w_wrap) r_bclk <= ~r_bclk;

      // The word rotates rather than shifts: after 16+15 rotations its bit 0
      // sits at the MSB, giving the one-bit I2S delay into the next slot 0.
      if (w_fall) begin
        r_slot   <= w_slot_nxt;
        r_lrck   <= (w_slot_nxt >= SW'(DATA_W));
        r_dacdat <= r_shift[DATA_W-1];
        r_shift  <= w_load ? w_frame_word
                           : {r_shift[DATA_W-2:0], r_shift[DATA_W-1]};
      end

      if (w_load) begin
        if (r_buf_full) begin
          r_last     <= r_buf;
          r_buf_full <= 1'b0;
        end else begin
          r_underrun <= 1'b1;
        end
      end

      // Write after load so a same-cycle strobe refills the buffer.
      if (i_valid) begin
        r_buf      <= i_data;
        r_buf_full <= 1'b1;
        if (r_buf_full && !w_load) r_overflow <= 1'b1;
      end
    end
  end

  assign o_bclk     = r_bclk;
  assign o_lrck     = r_lrck;
  assign o_dacdat   = r_dacdat;
  assign o_buf_full = r_buf_full;
  assign o_underrun = r_underrun;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: directed scenarios then random strobes, every cycle
// checked against a time-indexed frame model.
module tb_audio_i2s_tx;
  localparam int BD = 2;
  localparam int DW = 16;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_mute = 1'b0;
  logic          o_bclk, o_lrck, o_dacdat, o_buf_full, o_underrun, o_overflow;

  audio_i2s_tx #(.BCLK_DIV(BD), .DATA_W(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .i_mute(i_mute), .o_bclk(o_bclk), .o_lrck(o_lrck), .o_dacdat(o_dacdat),
    .o_buf_full(o_buf_full), .o_underrun(o_underrun), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: t counts clocks since reset release; outputs derive from t.
  int          t;
  int          m_s;
  bit          m_fell;
  bit [DW-1:0] m_buf, m_last, m_cur, m_prev;
  bit          m_full;
  bit          e_bclk, e_lrck, e_dat, e_und, e_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model(input bit rst, input bit v, input bit [DW-1:0] d, input bit m);
    int  k;
    bit  load;
    load   = 0;
    m_fell = 0;
    if (rst) begin
      t = 0; m_s = 2*DW-1; e_bclk = 0; e_lrck = 1; e_dat = 0; e_und = 0; e_ovf = 0;
      m_buf = '0; m_last = '0; m_cur = '0; m_prev = '0; m_full = 0;
      return;
    end
    t++;
    e_und = 0;
    e_ovf = 0;
    if (t % BD == 0) begin
      e_bclk = ((t / BD) % 2) == 1;
      if (!e_bclk) begin
        m_fell = 1;
        k      = t / (2*BD);
        m_s    = (k - 1) % (2*DW);
        e_lrck = (m_s >= DW);
        if (m_s == 0) begin
          load   = 1;
          m_prev = m_cur;
          if (m_full) begin
            m_cur  = m ? '0 : m_buf;
            m_last = m_buf;
            m_full = 0;
          end else begin
            m_cur = m ? '0 : m_last;
            e_und = 1;
          end
        end
        if (m_s == 0)       e_dat = m_prev[0];
        else if (m_s <= DW) e_dat = m_cur[DW - m_s];
        else                e_dat = m_cur[2*DW - m_s];
      end
    end
    if (v) begin
      if (m_full && !load) e_ovf = 1;
      m_buf  = d;
      m_full = 1;
    end
  endtask

  task automatic tick(input bit rst, input bit v, input bit [DW-1:0] d, input bit m);
    i_rst = rst; i_valid = v; i_data = d; i_mute = m;
    @(posedge i_clk);
    model(rst, v, d, m);
    #1;
    chk("bclk", o_bclk, e_bclk);
    chk("lrck", o_lrck, e_lrck);
    chk("dacdat", o_dacdat, e_dat);
    chk("buf_full", o_buf_full, m_full);
    chk("underrun", o_underrun, e_und);
    chk("overflow", o_overflow, e_ovf);
  endtask

  task automatic idle();
    tick(0, 0, '0, 0);
  endtask

  task automatic run_to_slot(input int s);
    for (int n = 0; n < 400; n++) begin
      idle();
      if (m_fell && m_s == s) return;
    end
    n_cmp++; n_err++;
    $error("FAIL run_to_slot observed=timeout expected=slot %0d", s);
  endtask

  task automatic next_fall();
    for (int n = 0; n < 20; n++) begin
      idle();
      if (m_fell) return;
    end
    n_cmp++; n_err++;
    $error("FAIL next_fall observed=timeout expected=bclk fall");
  endtask

  // Collect 16 serial bits starting at slot s (1 = left word, 17 = right word).
  task automatic get_word(input int s, output logic [DW-1:0] w);
    run_to_slot(s);
    for (int i = DW-1; i >= 0; i--) begin
      w[i] = o_dacdat;
      if (i > 0) next_fall();
    end
  endtask

  task automatic reset_and_check();
    tick(1, 0, '0, 0);
    tick(1, 0, '0, 0);
    chk("rst_lrck", o_lrck, 1'b1);
    chk("rst_full", o_buf_full, 1'b0);
    idle();
    chk("rel1_bclk", o_bclk, 1'b0);
    idle();
    chk("rel2_bclk", o_bclk, 1'b1);
  endtask

  logic [DW-1:0] w;
  int            n_und;

  initial begin
    // Idle after reset: underrun every frame, data stays zero.
    reset_and_check();
    n_und = 0;
    for (int i = 0; i < 384; i++) begin
      idle();
      if (o_underrun) n_und++;
    end
    chk("idle_underruns", n_und, 3);

    // Sample before the first slot 0.
    reset_and_check();
    tick(0, 1, 16'hA5C3, 0);
    run_to_slot(0);
    chk("a5c3_no_underrun", o_underrun, 1'b0);
    chk("a5c3_buf_cleared", o_buf_full, 1'b0);
    get_word(1, w);  chk("a5c3_left", w, 16'hA5C3);
    tick(0, 1, 16'h8001, 0);
    get_word(17, w); chk("a5c3_right", w, 16'hA5C3);

    // 8001 then 7FFE, then starvation repeats 7FFE.
    get_word(1, w);  chk("8001_left", w, 16'h8001);
    tick(0, 1, 16'h7FFE, 0);
    get_word(1, w);  chk("7ffe_left", w, 16'h7FFE);
    run_to_slot(0);
    chk("repeat_underrun", o_underrun, 1'b1);
    get_word(1, w);  chk("7ffe_repeat", w, 16'h7FFE);

    // Two strobes in one frame: newest wins.
    tick(0, 1, 16'h1111, 0);
    idle(); idle(); idle();
    tick(0, 1, 16'h2222, 0);
    chk("ovf_pulse", o_overflow, 1'b1);
    get_word(1, w);  chk("ovf_newest", w, 16'h2222);

    // Strobe exactly on the load clock.
    tick(0, 1, 16'h1234, 0);
    run_to_slot(31);
    idle(); idle(); idle();
    tick(0, 1, 16'h3C3C, 0);
    chk("coinc_no_ovf", o_overflow, 1'b0);
    chk("coinc_full", o_buf_full, 1'b1);
    get_word(1, w);  chk("coinc_1234", w, 16'h1234);
    get_word(1, w);  chk("coinc_3c3c", w, 16'h3C3C);

    // Mute consumes the buffer but sends zeros.
    tick(0, 1, 16'hFFFF, 0);
    run_to_slot(31);
    idle(); idle(); idle();
    tick(0, 0, '0, 1);
    chk("mute_consumed", o_buf_full, 1'b0);
    get_word(1, w);  chk("mute_left", w, 16'h0000);
    get_word(17, w); chk("mute_right", w, 16'h0000);
    get_word(1, w);  chk("after_mute", w, 16'hFFFF);

    // Reset mid-frame at slot 20.
    tick(0, 1, 16'h5A5A, 0);
    run_to_slot(20);
    tick(1, 0, '0, 0);
    chk("midrst_bclk", o_bclk, 1'b0);
    chk("midrst_lrck", o_lrck, 1'b1);
    chk("midrst_dat", o_dacdat, 1'b0);
    chk("midrst_full", o_buf_full, 1'b0);
    reset_and_check();

    // Random strobes and mute against the model.
    for (int i = 0; i < 3000; i++) begin
      tick(0, ($urandom_range(0, 99) < 2), DW'($urandom), ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
